// File: rtl/fifo_pack_pkg.sv
// Shared types and defaults for the FIFO word packer.
package fifo_pack_pkg;

  localparam int unsigned BYTE_W             = 8;
  localparam int unsigned DEF_BYTES_PER_WORD = 4;
  localparam int unsigned DEF_TIMEOUT_CYC    = 16;

  typedef enum logic [1:0] {
    FILL,
    HOLD,
    FLUSH
  } state_e;

endpackage

// File: rtl/fifo_word_packer_if.sv
// FIFO read side plus packed-word valid/ready output of the word packer.
interface fifo_word_packer_if
  import fifo_pack_pkg::*;
#(
  parameter int unsigned BYTES_PER_WORD = DEF_BYTES_PER_WORD
);

  logic                               fifo_empty;
  logic [BYTE_W-1:0]                  fifo_data;
  logic                               fifo_r_en;
  logic                               flush;
  logic [BYTE_W*BYTES_PER_WORD-1:0]   word_data;
  logic [BYTES_PER_WORD-1:0]          word_keep;
  logic                               word_valid;
  logic                               word_ready;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  flush,
    input  word_ready,
    output fifo_r_en,
    output word_data,
    output word_keep,
    output word_valid
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output flush,
    output word_ready,
    input  fifo_r_en,
    input  word_data,
    input  word_keep,
    input  word_valid
  );

endinterface

// File: rtl/fifo_pack_timer.sv
// Idle counter for the packer: counts idle cycles and pulses once on reaching TIMEOUT_CYC.
module fifo_pack_timer
  import fifo_pack_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expire
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CntW'(TIMEOUT_CYC))) begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  // Saturating count gives a single pulse per idle stretch.
  assign o_expire = i_inc && !i_clear && (r_cnt == CntW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/fifo_word_packer.sv
// Pops bytes from an 8-bit FIFO and packs them little-endian into keep-masked words.
// Optional idle-timeout auto-flush is enabled by defining FIFO_PACK_TIMEOUT_EN.
module fifo_word_packer
  import fifo_pack_pkg::*;
#(
  parameter int unsigned BYTES_PER_WORD = DEF_BYTES_PER_WORD,
  parameter int unsigned TIMEOUT_CYC    = DEF_TIMEOUT_CYC
) (
  input  logic                clk,
  input  logic                reset,
  fifo_word_packer_if.master  bus
);

  localparam int unsigned CNT_W  = $clog2(BYTES_PER_WORD + 1);
  localparam int unsigned WORD_W = BYTE_W * BYTES_PER_WORD;

  if ((BYTES_PER_WORD < 2) || (BYTES_PER_WORD > 8) || (TIMEOUT_CYC < 1)) begin : g_param_err
    $error("fifo_word_packer: BYTES_PER_WORD must be 2..8 and TIMEOUT_CYC nonzero");
  end

  state_e                    r_state, w_state_d;
  logic [WORD_W-1:0]         r_acc, w_acc_d;
  logic [CNT_W-1:0]          r_acc_cnt, w_acc_cnt_d;
  logic                      r_inflight;
  logic [WORD_W-1:0]         r_word_data, w_word_data_d;
  logic [BYTES_PER_WORD-1:0] r_word_keep, w_word_keep_d;
  logic                      r_word_valid, w_word_valid_d;

  logic                      w_out_free;
  logic                      w_complete;
  logic                      w_room;
  logic                      w_rd_en;
  logic                      w_load;
  logic                      w_flush_req;
  logic [WORD_W-1:0]         w_part_data;
  logic [BYTES_PER_WORD-1:0] w_part_keep;

  assign w_out_free = !r_word_valid || bus.word_ready;
  assign w_complete = r_inflight && (r_acc_cnt == CNT_W'(BYTES_PER_WORD - 1));

  // A completing byte that drains straight into a free output register frees the
  // whole accumulator at this edge, so popping the next byte keeps full rate.
  assign w_room  = ((int'(r_acc_cnt) + int'(r_inflight)) < int'(BYTES_PER_WORD)) ||
                   (w_complete && w_out_free);
  assign w_rd_en = reset && !bus.fifo_empty && (r_state == FILL) && w_room;

`ifdef FIFO_PACK_TIMEOUT_EN
  logic w_timeout;

  fifo_pack_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (r_inflight || w_load),
    .i_inc    ((r_acc_cnt != '0) && !r_inflight),
    .o_expire (w_timeout)
  );

  assign w_flush_req = bus.flush || w_timeout;
`else
  assign w_flush_req = bus.flush;
`endif

  // Partial word: only the first acc_cnt bytes survive, stale slots read as zero.
  always_comb begin
    w_part_data = '0;
    w_part_keep = '0;
    for (int i = 0; i < int'(BYTES_PER_WORD); i++) begin
      if (i < int'(r_acc_cnt)) begin
        w_part_keep[i]                 = 1'b1;
        w_part_data[i*BYTE_W +: BYTE_W] = r_acc[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_acc_d        = r_acc;
    w_acc_cnt_d    = r_acc_cnt;
    w_word_data_d  = r_word_data;
    w_word_keep_d  = r_word_keep;
    w_word_valid_d = r_word_valid && !bus.word_ready;
    w_load         = 1'b0;

    if (r_inflight) begin
      w_acc_d[int'(r_acc_cnt)*BYTE_W +: BYTE_W] = bus.fifo_data;
      w_acc_cnt_d                               = r_acc_cnt + CNT_W'(1);
    end

    if (w_complete) begin
      // Completion wins over any pending flush in FILL or FLUSH.
      if (w_out_free) begin
        w_load        = 1'b1;
        w_word_data_d = w_acc_d;
        w_word_keep_d = '1;
        w_acc_cnt_d   = '0;
        w_state_d     = FILL;
      end else begin
        w_state_d = HOLD;
      end
    end else begin
      unique case (r_state)
        FILL: begin
          if (w_flush_req && (r_inflight || (r_acc_cnt != '0))) begin
            w_state_d = FLUSH;
          end
        end
        FLUSH: begin
          if (!r_inflight) begin
            if (r_acc_cnt == '0) begin
              w_state_d = FILL;
            end else if (w_out_free) begin
              w_load        = 1'b1;
              w_word_data_d = w_part_data;
              w_word_keep_d = w_part_keep;
              w_acc_cnt_d   = '0;
              w_state_d     = FILL;
            end
          end
        end
        HOLD: begin
          if (w_out_free) begin
            w_load        = 1'b1;
            w_word_data_d = r_acc;
            w_word_keep_d = '1;
            w_acc_cnt_d   = '0;
            w_state_d     = FILL;
          end
        end
        default: w_state_d = FILL;
      endcase
    end

    if (w_load) begin
      w_word_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= FILL;
      r_acc        <= '0;
      r_acc_cnt    <= '0;
      r_inflight   <= 1'b0;
      r_word_data  <= '0;
      r_word_keep  <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_acc        <= w_acc_d;
      r_acc_cnt    <= w_acc_cnt_d;
      r_inflight   <= w_rd_en;
      r_word_data  <= w_word_data_d;
      r_word_keep  <= w_word_keep_d;
      r_word_valid <= w_word_valid_d;
    end
  end

  assign bus.fifo_r_en  = w_rd_en;
  assign bus.word_data  = r_word_data;
  assign bus.word_keep  = r_word_keep;
  assign bus.word_valid = r_word_valid;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer with a behavioural FIFO and an output word monitor.
module tb_fifo_word_packer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fifo_word_packer_if #(.BYTES_PER_WORD(4)) bus_if ();

  fifo_word_packer #(
    .BYTES_PER_WORD (4),
    .TIMEOUT_CYC    (16)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_if)
  );

  // Behavioural FIFO: one-cycle read latency, emptied by reset.
  logic [7:0] fifo_mem [256];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  assign bus_if.fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr           <= wr_ptr;
      bus_if.fifo_data <= 8'h00;
    end else if (bus_if.fifo_r_en) begin
      bus_if.fifo_data <= fifo_mem[rd_ptr[7:0]];
      rd_ptr           <= rd_ptr + 1;
    end
  end

  // Monitor: handshakes, pops and pops-while-empty, sampled mid-cycle.
  logic [31:0] got_data [$];
  logic [3:0]  got_keep [$];
  int          n_pops = 0;
  int          n_viol = 0;

  always @(negedge clk) begin
    if (bus_if.word_valid && bus_if.word_ready) begin
      got_data.push_back(bus_if.word_data);
      got_keep.push_back(bus_if.word_keep);
    end
    if (bus_if.fifo_r_en) n_pops <= n_pops + 1;
    if (bus_if.fifo_r_en && bus_if.fifo_empty) n_viol <= n_viol + 1;
  end

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] bytes_in;
    int          n;
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr[7:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic check_word(input int idx, input logic [31:0] d, input logic [3:0] k,
                            input string name);
    if (idx < got_data.size()) begin
      check({name, "_data"}, 64'(got_data[idx]), 64'(d));
      check({name, "_keep"}, 64'(got_keep[idx]), 64'(k));
    end else begin
      n_vec++;
      n_err++;
      $display("FAIL %s: word %0d missing, got %0d words", name, idx, got_data.size());
    end
  endtask

  task automatic wait_words(input int n, input int budget, input string name);
    int k = 0;
    while ((got_data.size() < n) && (k < budget)) begin
      tick();
      k++;
    end
    if (got_data.size() < n) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: timeout, got %0d words, required %0d", name, got_data.size(), n);
    end
  endtask

  task automatic pulse_flush();
    bus_if.flush = 1'b1;
    tick();
    bus_if.flush = 1'b0;
  endtask

  initial begin
    int base;
    int pops0;
    bit run_ok;

    vecs[0] = '{32'hEFBEADDE, 4, 32'hEFBEADDE, 4'hF};
    vecs[1] = '{32'h00CCBBAA, 3, 32'h00CCBBAA, 4'h7};
    vecs[2] = '{32'h00000001, 1, 32'h00000001, 4'h1};
    vecs[3] = '{32'h00000FF0, 2, 32'h00000FF0, 4'h3};
    vecs[4] = '{32'hFF7F0080, 4, 32'hFF7F0080, 4'hF};

    bus_if.flush      = 1'b0;
    bus_if.word_ready = 1'b0;

    // Reset state, with a byte waiting in the FIFO.
    tick();
    push(8'h5A);
    #1;
    check("rst_r_en",  64'(bus_if.fifo_r_en),  64'd0);
    check("rst_valid", 64'(bus_if.word_valid), 64'd0);
    check("rst_data",  64'(bus_if.word_data),  64'd0);
    check("rst_keep",  64'(bus_if.word_keep),  64'd0);
    tick();
    rst_n             = 1'b1;
    bus_if.word_ready = 1'b1;
    tick();

    // Table vectors: full words drain by themselves, partial ones need a flush.
    for (int i = 0; i < 5; i++) begin
      base = got_data.size();
      for (int j = 0; j < vecs[i].n; j++) push(vecs[i].bytes_in[8*j +: 8]);
      repeat (6) tick();
      if (vecs[i].n < 4) pulse_flush();
      wait_words(base + 1, 20, $sformatf("vec%0d_wait", i));
      repeat (3) tick();
      check_word(base, vecs[i].exp_data, vecs[i].exp_keep, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_count", i), 64'(got_data.size() - base), 64'd1);
    end

    // Full-rate packing: eight back-to-back pops.
    base = got_data.size();
    for (int j = 1; j <= 8; j++) push(8'(j * 8'h11));
    run_ok = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (!bus_if.fifo_r_en) run_ok = 1'b0;
    end
    check("fullrate_r_en_run", 64'(run_ok), 64'd1);
    @(negedge clk);
    check("fullrate_r_en_stop", 64'(bus_if.fifo_r_en), 64'd0);
    wait_words(base + 2, 20, "fullrate_wait");
    check_word(base,     32'h44332211, 4'hF, "fullrate_w0");
    check_word(base + 1, 32'h88776655, 4'hF, "fullrate_w1");

    // Backpressure: pops stop at 8 bytes, held word is stable, then three words drain.
    tick();
    bus_if.word_ready = 1'b0;
    base  = got_data.size();
    pops0 = n_pops;
    for (int j = 1; j <= 12; j++) push(8'(j));
    repeat (20) tick();
    check("bp_pops", 64'(n_pops - pops0), 64'd8);
    @(negedge clk);
    check("bp_r_en",   64'(bus_if.fifo_r_en),  64'd0);
    check("bp_valid",  64'(bus_if.word_valid), 64'd1);
    check("bp_data_a", 64'(bus_if.word_data),  64'h04030201);
    repeat (3) tick();
    check("bp_data_b", 64'(bus_if.word_data),  64'h04030201);
    check("bp_keep",   64'(bus_if.word_keep),  64'hF);
    bus_if.word_ready = 1'b1;
    wait_words(base + 3, 40, "bp_wait");
    repeat (4) tick();
    check_word(base,     32'h04030201, 4'hF, "bp_w0");
    check_word(base + 1, 32'h08070605, 4'hF, "bp_w1");
    check_word(base + 2, 32'h0C0B0A09, 4'hF, "bp_w2");
    check("bp_count", 64'(got_data.size() - base), 64'd3);

    // Flush with nothing accumulated is a no-op.
    base = got_data.size();
    pulse_flush();
    repeat (10) tick();
    check("flush_empty_count", 64'(got_data.size() - base), 64'd0);

    // Flush landing on the fourth byte: one full word only.
    base = got_data.size();
    for (int j = 0; j < 4; j++) push(8'(8'h31 + j));
    repeat (4) tick();
    pulse_flush();
    repeat (10) tick();
    check("flush_co_count", 64'(got_data.size() - base), 64'd1);
    check_word(base, 32'h34333231, 4'hF, "flush_co");

    // Two bytes then an empty FIFO.
    base = got_data.size();
    push(8'h21);
    push(8'h22);
`ifdef FIFO_PACK_TIMEOUT_EN
    wait_words(base + 1, 40, "timeout_wait");
    check_word(base, 32'h00002221, 4'h3, "timeout");
`else
    repeat (100) tick();
    check("no_timeout_count", 64'(got_data.size() - base), 64'd0);
    pulse_flush();
    wait_words(base + 1, 20, "drain_wait");
    check_word(base, 32'h00002221, 4'h3, "drain");
`endif
    repeat (3) tick();

    // Reset mid-word with a word held in the output register.
    bus_if.word_ready = 1'b0;
    for (int j = 0; j < 4; j++) push(8'(8'h51 + j));
    push(8'h41);
    push(8'h42);
    repeat (12) tick();
    check("mid_valid_pre", 64'(bus_if.word_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus_if.word_valid), 64'd0);
    check("mid_rst_data",  64'(bus_if.word_data),  64'd0);
    check("mid_rst_keep",  64'(bus_if.word_keep),  64'd0);
    check("mid_rst_r_en",  64'(bus_if.fifo_r_en),  64'd0);
    repeat (2) tick();
    rst_n             = 1'b1;
    bus_if.word_ready = 1'b1;
    tick();
    base = got_data.size();
    for (int j = 0; j < 4; j++) push(8'(8'h61 + j));
    wait_words(base + 1, 20, "post_rst_wait");
    repeat (5) tick();
    check_word(base, 32'h64636261, 4'hF, "post_rst");
    check("post_rst_count", 64'(got_data.size() - base), 64'd1);

    check("r_en_while_empty", 64'(n_viol), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
